// File: rtl/hs_ram_arbiter.sv
// hs_ram_arbiter: shares the work-RAM port between the core CPU and the hiscore engine.
// Define HS_VBL_SYNC_EN to start each hiscore access only at a vblank rising edge.
module hs_ram_arbiter #(
    parameter int          AW        = 16,
    parameter int          DRAIN_CYC = 4,
    parameter logic [23:0] MAX_HOLD  = 24'd2000000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vblank,
    input  logic          user_pause,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_we,
    output logic [7:0]    hs_rdata,
    output logic          hs_grant,
    output logic          hs_abort,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    input  logic          cpu_we,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_pause,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata
);
    typedef enum logic [2:0] {
        IDLE,
`ifdef HS_VBL_SYNC_EN
        WAIT_VBL,
`endif
        DRAIN,
        GRANT,
        RELEASE
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [23:0] hold_q, hold_d;
    logic        sel_q, sel_d;
    logic        grant_q, grant_d;
    logic        abort_q, abort_d;
    logic        pause_q, pause_d;
    logic        block_q, block_d;

`ifdef HS_VBL_SYNC_EN
    logic        vbl_q;
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) vbl_q <= 1'b0;
        else       vbl_q <= vblank;
`else
    logic        unused_vblank;
    assign unused_vblank = vblank;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        abort_d = 1'b0;
        pause_d = pause_q;
        // After a timeout the request must be seen low before it can win again
        block_d = hs_req ? block_q : 1'b0;
        case (state_q)
            IDLE: if (hs_req && !block_q) begin
`ifdef HS_VBL_SYNC_EN
                state_d = WAIT_VBL;
`else
                state_d = DRAIN;
                cnt_d   = 8'(DRAIN_CYC);
                pause_d = 1'b1;
`endif
            end
`ifdef HS_VBL_SYNC_EN
            WAIT_VBL: begin
                if (!hs_req) state_d = IDLE;
                else if (vblank && !vbl_q) begin
                    state_d = DRAIN;
                    cnt_d   = 8'(DRAIN_CYC);
                    pause_d = 1'b1;
                end
            end
`endif
            DRAIN: begin
                if (!hs_req) begin
                    state_d = IDLE;
                    pause_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = GRANT;
                        sel_d   = 1'b1;
                        grant_d = 1'b1;
                        hold_d  = '0;
                    end
                end
            end
            GRANT: begin
                hold_d = (hold_q == 24'hFFFFFF) ? hold_q : hold_q + 24'd1;
                if (!hs_req) begin
                    state_d = RELEASE;
                    sel_d   = 1'b0;
                    grant_d = 1'b0;
                end else if (MAX_HOLD != 24'd0 && hold_d == MAX_HOLD) begin
                    state_d = RELEASE;
                    sel_d   = 1'b0;
                    grant_d = 1'b0;
                    abort_d = 1'b1;
                    block_d = 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
                pause_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
                sel_d   = 1'b0;
                grant_d = 1'b0;
                pause_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            sel_q   <= 1'b0;
            grant_q <= 1'b0;
            abort_q <= 1'b0;
            pause_q <= 1'b0;
            block_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            abort_q <= abort_d;
            pause_q <= pause_d;
            block_q <= block_d;
        end
    end

    assign hs_grant  = grant_q;
    assign hs_abort  = abort_q;
    assign cpu_pause = user_pause | pause_q;
    assign ram_addr  = sel_q ? hs_addr : cpu_addr;
    assign ram_wdata = sel_q ? hs_wdata : cpu_wdata;
    assign ram_we    = sel_q ? (hs_we & grant_q) : cpu_we;
    assign hs_rdata  = ram_rdata;
    assign cpu_rdata = ram_rdata;
endmodule

// File: doc/hs_ram_arbiter.md
Name: hs_ram_arbiter

Overview:
- Shares the game work-RAM port between the running core CPU and the hiscore save/restore engine.
- Sequences each hiscore access: request -> optional vblank alignment -> CPU pause -> drain -> grant -> release.
- Its pause output feeds the core pause input alongside the user pause toggle.
- Sits between the hiscore engine's ram_address/data_to_ram/ram_write/ram_access signals and the core's hs_* port.

Parameters:
- AW, 16, RAM address width.
- DRAIN_CYC, 4, cycles the CPU must be paused before the grant (lets in-flight core bus cycles finish); range 1..255.
- MAX_HOLD, 24'd2000000, maximum cycles in GRANT before a forced release; 0 disables the timeout.

Ports:
- clk_sys  in  1  system clock (24.576 MHz domain).
- reset  in  1  asynchronous, active-high reset.
- vblank  in  1  core vertical blank, synchronous to clk_sys.
- user_pause  in  1  user pause toggle, ORed into cpu_pause.
- hs_req  in  1  hiscore engine requests the RAM; level, held for the whole transaction.
- hs_addr  in  AW  hiscore RAM address.
- hs_wdata  in  8  hiscore write data.
- hs_we  in  1  hiscore write strobe.
- hs_rdata  out  8  read data to the hiscore engine.
- hs_grant  out  1  RAM port owned by the hiscore engine.
- hs_abort  out  1  one-cycle pulse when the timeout revokes a grant.
- cpu_addr  in  AW  core address.
- cpu_wdata  in  8  core write data.
- cpu_we  in  1  core write strobe.
- cpu_rdata  out  8  read data to the core.
- cpu_pause  out  1  pause to the core.
- ram_addr  out  AW  shared RAM address.
- ram_wdata  out  8  shared RAM write data.
- ram_we  out  1  shared RAM write enable.
- ram_rdata  in  8  shared RAM read data; synchronous, 1-cycle latency.

Behaviour:
- States: IDLE, WAIT_VBL, DRAIN, GRANT, RELEASE.
- Reset values: state=IDLE, sel_hs=0, hs_grant=0, hs_abort=0, internal pause=0, counters=0. cpu_pause = user_pause during reset.
- IDLE:
  - hs_req=1 -> WAIT_VBL when HS_VBL_SYNC_EN is defined; otherwise -> DRAIN with counter loaded to DRAIN_CYC.
- WAIT_VBL:
  - Waits for a vblank rising edge (registered previous vblank). A request arriving while vblank is already high waits for the next frame.
  - On the edge -> DRAIN, counter=DRAIN_CYC.
- DRAIN:
  - Internal pause=1; counter decrements each cycle.
  - CPU stays on the RAM port.
  - Counter reaches 0 -> GRANT with sel_hs=1, hs_grant=1, hold counter cleared.
- GRANT:
  - RAM port follows hs_*.
  - hs_req=0 -> RELEASE.
  - Hold counter reaches MAX_HOLD (MAX_HOLD != 0) -> RELEASE and hs_abort=1 for one cycle.
- RELEASE:
  - sel_hs=0 and hs_grant=0 on entry; internal pause stays 1 for this one cycle.
  - Next cycle -> IDLE with pause=0.
  - If hs_req is still high after an abort, it is ignored until it has been seen low at least once (rearm flag).
- hs_req dropped in WAIT_VBL or DRAIN: -> IDLE next cycle, pause cleared, no grant issued.
- Muxing:
  - ram_addr/ram_wdata/ram_we = sel_hs ? hs_* : cpu_*. Mux is combinational from the registered sel_hs.
  - hs_we is ignored (ram_we=0 from the hiscore side) whenever hs_grant=0.
- Read data:
  - hs_rdata = ram_rdata; cpu_rdata = ram_rdata.
  - Read latency is 1 cycle from the address for both requesters.
- cpu_pause = user_pause | internal pause. It asserts the cycle after entering DRAIN and deasserts the cycle after leaving RELEASE.
- Grant latency from hs_req rising, without vblank sync: DRAIN_CYC+1 cycles.
- Hold counter width: 24 bits, saturating.
- Reset mid-grant: immediate return to CPU ownership; hs_grant drops asynchronously.

Optional Feature:
- HS_VBL_SYNC_EN defined:
  - The WAIT_VBL state exists.
  - The CPU is only paused starting at a vblank rising edge, so the hiscore access never interrupts active-video game logic.
- Undefined:
  - WAIT_VBL is removed.
  - IDLE goes directly to DRAIN; vblank is unused.

Test Plan:
- No HS_VBL_SYNC_EN, DRAIN_CYC=4: hs_req high at cycle 0 -> cpu_pause=1 at cycle 1, hs_grant=1 at cycle 5, ram_addr switches to hs_addr=0x6100 the same cycle.
- HS_VBL_SYNC_EN, request raised with vblank already high -> no pause until the next vblank 0->1 edge; grant DRAIN_CYC+1 cycles after that edge.
- Granted, hs_we=1, hs_addr=0x6100, hs_wdata=0xA5 -> ram_we=1, ram_wdata=0xA5. Then cpu_we=1 in the same cycle -> no CPU write reaches the RAM. Read back 0x6100 -> hs_rdata=0xA5 one cycle later.
- MAX_HOLD=16, hs_req held high -> hs_abort pulses at grant+16, hs_grant=0, cpu_pause drops one cycle later. No regrant until hs_req goes 0 then 1.
- hs_req dropped at DRAIN cycle 2 -> IDLE, hs_grant never asserts, cpu_pause=0 next cycle. With user_pause=1 throughout, cpu_pause stays 1.
- reset asserted mid-GRANT -> hs_grant=0 and ram_addr=cpu_addr without waiting for a clock edge. After release, state=IDLE.
